// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, signed (DIV) or unsigned
// (DIVU). One quotient bit per cycle, 32 BUSY cycles per operation.
// Result layout matches the HI/LO unit: out_data = {quotient, remainder}.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Operation context captured at accept
    logic [WIDTH-1:0] quo;       // holds |dividend| first, quotient bits shift in from the LSB
    logic [WIDTH-1:0] dvs_abs;   // divisor magnitude
    logic [WIDTH:0]   rem;       // partial remainder, one guard bit for the trial subtract
    logic             neg_q;     // quotient must be negated
    logic             neg_r;     // remainder must be negated (dividend was negative)
    logic             zero_div;  // divisor was zero
    logic [CW-1:0]    count;

    // Sign handling of the incoming operands
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs_in;
    logic [WIDTH-1:0] dvs_abs_in;

    assign dvd_neg    = is_signed & dividend[WIDTH-1];
    assign dvs_neg    = is_signed & divisor[WIDTH-1];
    assign dvd_abs_in = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_abs_in = dvs_neg ? (~divisor + 1'b1) : divisor;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             last;

    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_abs};
    assign q_bit     = ~trial[WIDTH];
    assign rem_step  = q_bit ? trial : rem_shift;
    assign quo_step  = {quo[WIDTH-2:0], q_bit};
    assign last      = (count == CW'(WIDTH - 1));

    // Final sign fix-up. For a zero divisor every trial succeeds, so the
    // remainder magnitude ends up as |dividend|; restoring its sign gives
    // back the dividend as sampled, and only the quotient needs forcing.
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign q_final = zero_div ? '1
                   : (neg_q ? (~quo_step + 1'b1) : quo_step);
    assign r_final = neg_r ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values, independent of block order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; flush overrides every transition
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Datapath: load at accept, one restoring step per BUSY cycle, register result on the last step
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only count and out_data have defined reset values; the
            // operand/remainder registers are always loaded at accept before use.
            count    <= '0;
            out_data <= '0;
        end else if (state == IDLE) begin
            if (in_valid && !flush) begin
                quo      <= dvd_abs_in;
                dvs_abs  <= dvs_abs_in;
                rem      <= '0;
                neg_q    <= dvd_neg ^ dvs_neg;
                neg_r    <= dvd_neg;
                zero_div <= (divisor == '0);
                count    <= '0;
            end
        end else if (state == BUSY) begin
            quo   <= quo_step;
            rem   <= rem_step;
            count <= count + 1'b1;
            if (last && !flush) begin
                out_data <= {q_final, r_final};
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vectors for div_iter. The stimulus process pushes
// expected results into a scoreboard; a negedge monitor pops and compares
// on every result handshake and checks the fixed 33-cycle latency.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    div_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [63:0] exp;
        int          issue_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and hold in_valid through its accept edge
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push, input string name);
        int   n = 0;
        exp_t e;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        if (push) begin
            e.name      = name;
            e.exp       = exp;
            e.issue_cyc = cyc;
            sb.push_back(e);
        end
        tick();
        in_valid  = 1'b0;
        dividend  = 32'hdeadbeef;
        divisor   = 32'h0;
        is_signed = ~sgn;
    endtask

    // Wait until the monitor has consumed every expected result
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Monitor: latency on each rising out_valid, data on each handshake
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'd0);
                else check({sb[0].name, "_latency"}, 64'(cyc - sb[0].issue_cyc), 64'd33);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check(e.name, out_data, e.exp);
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data",  out_data,       64'd0);
        reset = 1'b0;
        tick();

        // Unsigned
        issue(1'b0, 32'd100,       32'd7,        {32'h0000000E, 32'h00000002}, 1'b1, "divu_100_7");
        drain();
        issue(1'b0, 32'hFFFFFFFF,  32'h00000010, {32'h0FFFFFFF, 32'h0000000F}, 1'b1, "divu_max_16");
        drain();
        issue(1'b0, 32'h80000000,  32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b1, "divu_msb_max");
        drain();
        // Signed sign combinations and overflow
        issue(1'b1, 32'hFFFFFFF9,  32'd2,        {32'hFFFFFFFD, 32'hFFFFFFFF}, 1'b1, "div_m7_2");
        drain();
        issue(1'b1, 32'd7,         32'hFFFFFFFE, {32'hFFFFFFFD, 32'h00000001}, 1'b1, "div_7_m2");
        drain();
        issue(1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, {32'h00000003, 32'hFFFFFFFF}, 1'b1, "div_m7_m2");
        drain();
        issue(1'b1, 32'h80000000,  32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 1'b1, "div_overflow");
        drain();
        // Divide by zero
        issue(1'b1, 32'h12345678,  32'd0,        {32'hFFFFFFFF, 32'h12345678}, 1'b1, "div_by_zero");
        drain();
        issue(1'b1, 32'hFFFFFFF8,  32'd0,        {32'hFFFFFFFF, 32'hFFFFFFF8}, 1'b1, "div_neg_by_zero");
        drain();
        issue(1'b0, 32'd0,         32'd0,        {32'hFFFFFFFF, 32'h00000000}, 1'b1, "divu_0_0");
        drain();

        // Flush at BUSY cycle 10, then an immediate fresh operation
        issue(1'b0, 32'd100, 32'd7, 64'd0, 1'b0, "flushed");
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_in_ready",  64'(in_ready),  64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        issue(1'b0, 32'd9, 32'd3, {32'd3, 32'd0}, 1'b1, "after_flush_9_3");
        drain();

        // Backpressure: result held for 5 cycles, in_valid pulses ignored
        out_ready = 1'b0;
        issue(1'b0, 32'd1000, 32'd10, {32'd100, 32'd0}, 1'b1, "backpressure");
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_out_valid_rise", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data",  out_data,       {32'd100, 32'd0});
            check("bp_in_ready",   64'(in_ready),  64'd0);
            in_valid = (i % 2) == 0;
            dividend = 32'd55;
            divisor  = 32'd5;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_scoreboard_empty",  64'(sb.size()), 64'd0);

        // Reset during BUSY
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 64'd0, 1'b0, "reset_victim");
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("busy_reset_in_ready",  64'(in_ready),  64'd1);
        check("busy_reset_out_valid", 64'(out_valid), 64'd0);
        check("busy_reset_out_data",  out_data,       64'd0);
        reset = 1'b0;
        tick();

        // flush coincident with in_valid in IDLE: no accept, no result
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        in_valid  = 1'b1;
        flush     = 1'b1;
        tick();
        in_valid  = 1'b0;
        flush     = 1'b0;
        check("collision_in_ready", 64'(in_ready), 64'd1);
        repeat (40) tick();
        check("collision_no_result", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
